// File: rtl/uart_cmd_pkg.sv
// Shared types, opcodes and byte-list helpers for the UART command frame generator.
package uart_cmd_pkg;

    localparam logic [7:0] OP_WR      = 8'hAA;
    localparam logic [7:0] OP_RD      = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    // Per-byte line states of the serialiser.
    typedef enum logic [2:0] {
        FR_IDLE   = 3'd0,
        FR_START  = 3'd1,
        FR_DATA   = 3'd2,
        FR_PARITY = 3'd3,
        FR_STOP   = 3'd4
    } frame_state_e;

    // Command-level states of the top: waiting, a byte on the wire, inter-byte gap.
    typedef enum logic [1:0] {
        CS_IDLE = 2'd0,
        CS_SEND = 2'd1,
        CS_GAP  = 2'd2
    } cmd_state_e;

    typedef struct packed {
        cmd_type_e   typ;
        logic [3:0]  addr;
        logic [7:0]  data0;
        logic [7:0]  data1;
        logic [3:0]  fun;
        logic        par_en;
        logic        par_typ;
    } cmd_t;

    // Number of bytes in the frame sequence for a command type.
    function automatic logic [2:0] byte_count(input cmd_type_e typ);
        logic [2:0] n;
        n = 3'd2;
        case (typ)
            CMD_WR:     n = 3'd3;
            CMD_RD:     n = 3'd2;
            CMD_ALU_OP: n = 3'd4;
            default:    n = 3'd2;
        endcase
        return n;
    endfunction

    // Byte at position idx of a command's frame sequence.
    function automatic logic [7:0] cmd_byte(input cmd_t cmd, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (cmd.typ)
            CMD_WR: begin
                case (idx)
                    2'd0:    b = OP_WR;
                    2'd1:    b = {4'h0, cmd.addr};
                    default: b = cmd.data0;
                endcase
            end
            CMD_RD: begin
                b = (idx == 2'd0) ? OP_RD : {4'h0, cmd.addr};
            end
            CMD_ALU_OP: begin
                case (idx)
                    2'd0:    b = OP_ALU_OP;
                    2'd1:    b = cmd.data0;
                    2'd2:    b = cmd.data1;
                    default: b = {4'h0, cmd.fun};
                endcase
            end
            default: begin
                b = (idx == 2'd0) ? OP_ALU_NOP : {4'h0, cmd.fun};
            end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_frame_tx_byte_ser.sv
// Serialises one byte as a UART frame (start, 8 data LSB first, optional parity, stop).
module uart_byte_ser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_c,
    input  logic [7:0] byte_i,
    input  logic       par_en_i,
    input  logic       par_typ_i,
    output logic       tx_o,
    output logic       done_c
);

    localparam int unsigned       CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     CNT_MAX = CW'(CLKS_PER_BIT - 1);

    frame_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shr_q, shr_d;
    logic          par_en_q, par_en_d;
    logic          par_typ_q, par_typ_d;
    logic          tx_q, tx_d;
    logic          tick_c;
    logic          load_c;

    assign tick_c = (cnt_q == CNT_MAX);
    assign tx_o   = tx_q;

    // Next-state, bit timing, byte load and registered line level.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shr_d     = shr_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        done_c    = 1'b0;
        load_c    = 1'b0;
        tx_d      = 1'b1;

        if (state_q != FR_IDLE) begin
            cnt_d = tick_c ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            FR_IDLE: begin
                if (start_c) load_c = 1'b1;
            end
            FR_START: begin
                if (tick_c) begin
                    state_d = FR_DATA;
                    bit_d   = 3'd0;
                end
            end
            FR_DATA: begin
                if (tick_c) begin
                    if (bit_q == 3'd7) begin
                        state_d = par_en_q ? FR_PARITY : FR_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            FR_PARITY: begin
                if (tick_c) state_d = FR_STOP;
            end
            FR_STOP: begin
                if (tick_c) begin
                    done_c = 1'b1;
                    if (start_c) load_c = 1'b1;
                    else         state_d = FR_IDLE;
                end
            end
            default: state_d = FR_IDLE;
        endcase

        // A new byte can follow a stop bit directly when no gap is configured.
        if (load_c) begin
            state_d   = FR_START;
            shr_d     = byte_i;
            par_en_d  = par_en_i;
            par_typ_d = par_typ_i;
        end

        case (state_d)
            FR_START:  tx_d = 1'b0;
            FR_DATA:   tx_d = shr_d[bit_d];
            FR_PARITY: tx_d = (^shr_d) ^ par_typ_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; line idles high in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FR_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shr_q     <= 8'h00;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shr_q     <= shr_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/uart_cmd_frame_tx.sv
// Host-side command generator: expands one command into its byte sequence and sends it over UART.
module uart_cmd_frame_tx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned GAP_BITS     = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_TYPE,
    input  logic [3:0] CMD_ADDR,
    input  logic [7:0] CMD_DATA0,
    input  logic [7:0] CMD_DATA1,
    input  logic [3:0] CMD_FUN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic       TX_OUT,
    output logic       BUSY,
    output logic       CMD_DONE
);

    localparam int unsigned   GAP_CYC = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned   GW      = 12;
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC - 1);

    cmd_state_e    state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [1:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic          ser_start_c;
    logic          ser_done_c;
    logic [7:0]    ser_byte_c;
    logic [1:0]    last_idx_c;

    assign last_idx_c = 2'(byte_count(cmd_q.typ) - 3'd1);

    assign CMD_READY = ready_q;
    assign BUSY      = busy_q;
    assign CMD_DONE  = done_q;

    // Command sequencing: accept, advance byte index, time the inter-byte gap.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        done_d      = 1'b0;
        ser_start_c = 1'b0;

        case (state_q)
            CS_IDLE: begin
                if (CMD_VALID) begin
                    cmd_d.typ     = cmd_type_e'(CMD_TYPE);
                    cmd_d.addr    = CMD_ADDR;
                    cmd_d.data0   = CMD_DATA0;
                    cmd_d.data1   = CMD_DATA1;
                    cmd_d.fun     = CMD_FUN;
                    cmd_d.par_en  = PAR_EN;
                    cmd_d.par_typ = PAR_TYP;
                    idx_d         = 2'd0;
                    ser_start_c   = 1'b1;
                    state_d       = CS_SEND;
                end
            end
            CS_SEND: begin
                if (ser_done_c) begin
                    if (idx_q == last_idx_c) begin
                        state_d = CS_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        if (GAP_CYC == 0) begin
                            ser_start_c = 1'b1;
                        end else begin
                            state_d = CS_GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end
            CS_GAP: begin
                if (gap_q == GAP_MAX) begin
                    gap_d       = '0;
                    ser_start_c = 1'b1;
                    state_d     = CS_SEND;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = CS_IDLE;
        endcase

        busy_d     = (state_d != CS_IDLE);
        ready_d    = (state_d == CS_IDLE);
        ser_byte_c = cmd_byte(cmd_d, idx_d);
    end

    // Command latch, counters and registered handshake/status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= CS_IDLE;
            cmd_q   <= '0;
            idx_q   <= 2'd0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    uart_byte_ser #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk       (CLK),
        .rst       (RST),
        .start_c   (ser_start_c),
        .byte_i    (ser_byte_c),
        .par_en_i  (cmd_d.par_en),
        .par_typ_i (cmd_d.par_typ),
        .tx_o      (TX_OUT),
        .done_c    (ser_done_c)
    );

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Bench for uart_cmd_frame_tx: two instances (8 clk/bit with 1 gap bit, 4 clk/bit with no gap)
// share one command bus; a per-instance waveform model predicts every output cycle by cycle.
module tb_uart_cmd_frame_tx;

    localparam int A_CPB = 8;
    localparam int A_GAP = 1;
    localparam int B_CPB = 4;
    localparam int B_GAP = 0;

    typedef bit         wave_t[$];
    typedef logic [7:0] bytes_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_d0, cmd_d1;
    logic [3:0] cmd_fun;
    logic       par_en, par_typ;
    logic       rdy_a, tx_a, busy_a, done_a;
    logic       rdy_b, tx_b, busy_b, done_b;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    wave_t qa, qb;
    bit    dna = 1'b0, dnb = 1'b0;
    bit    idle_a, idle_b;
    logic [3:0] got_a, exp_a, got_b, exp_b;

    always #5 clk = ~clk;

    uart_cmd_frame_tx #(.CLKS_PER_BIT(A_CPB), .GAP_BITS(A_GAP)) u_dut_a (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(rdy_a),
        .CMD_TYPE(cmd_type), .CMD_ADDR(cmd_addr), .CMD_DATA0(cmd_d0), .CMD_DATA1(cmd_d1),
        .CMD_FUN(cmd_fun), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .TX_OUT(tx_a), .BUSY(busy_a), .CMD_DONE(done_a)
    );

    uart_cmd_frame_tx #(.CLKS_PER_BIT(B_CPB), .GAP_BITS(B_GAP)) u_dut_b (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(rdy_b),
        .CMD_TYPE(cmd_type), .CMD_ADDR(cmd_addr), .CMD_DATA0(cmd_d0), .CMD_DATA1(cmd_d1),
        .CMD_FUN(cmd_fun), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .TX_OUT(tx_b), .BUSY(busy_b), .CMD_DONE(done_b)
    );

    // Byte list of a command.
    function automatic bytes_t cmd_bytes(input logic [1:0] t, input logic [3:0] a,
                                         input logic [7:0] x, input logic [7:0] y,
                                         input logic [3:0] f);
        bytes_t r;
        case (t)
            2'd0: begin r.push_back(8'hAA); r.push_back({4'h0, a}); r.push_back(x); end
            2'd1: begin r.push_back(8'hBB); r.push_back({4'h0, a}); end
            2'd2: begin r.push_back(8'hCC); r.push_back(x); r.push_back(y); r.push_back({4'h0, f}); end
            default: begin r.push_back(8'hDD); r.push_back({4'h0, f}); end
        endcase
        return r;
    endfunction

    // Line level for every busy cycle of a command: bit periods expanded to clocks.
    function automatic wave_t build_wave(input int cpb, input int gap, input bytes_t bs,
                                         input bit pe, input bit pt);
        wave_t w;
        bit    lvl[$];
        for (int i = 0; i < bs.size(); i++) begin
            lvl.push_back(1'b0);
            for (int b = 0; b < 8; b++) lvl.push_back(bs[i][b]);
            if (pe) lvl.push_back((^bs[i]) ^ pt);
            lvl.push_back(1'b1);
            if (i < bs.size() - 1)
                for (int g = 0; g < gap; g++) lvl.push_back(1'b1);
        end
        for (int i = 0; i < lvl.size(); i++)
            for (int k = 0; k < cpb; k++) w.push_back(lvl[i]);
        return w;
    endfunction

    task automatic model_step();
        if (rst) begin
            qa.delete(); qb.delete(); dna = 1'b0; dnb = 1'b0;
        end else begin
            idle_a = (qa.size() == 0);
            idle_b = (qb.size() == 0);
            if (!idle_a) begin void'(qa.pop_front()); dna = (qa.size() == 0); end else dna = 1'b0;
            if (!idle_b) begin void'(qb.pop_front()); dnb = (qb.size() == 0); end else dnb = 1'b0;
            if (idle_a && cmd_valid)
                qa = build_wave(A_CPB, A_GAP, cmd_bytes(cmd_type, cmd_addr, cmd_d0, cmd_d1, cmd_fun), par_en, par_typ);
            if (idle_b && cmd_valid)
                qb = build_wave(B_CPB, B_GAP, cmd_bytes(cmd_type, cmd_addr, cmd_d0, cmd_d1, cmd_fun), par_en, par_typ);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) model_step();

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        got_a = {tx_a, busy_a, rdy_a, done_a};
        exp_a = {(qa.size() != 0) ? qa[0] : 1'b1, qa.size() != 0, qa.size() == 0, dna};
        got_b = {tx_b, busy_b, rdy_b, done_b};
        exp_b = {(qb.size() != 0) ? qb[0] : 1'b1, qb.size() != 0, qb.size() == 0, dnb};
        checks++;
        assert (got_a === exp_a) else begin
            errors++; $error("FAIL line_a t=%0t tx/busy/rdy/done got %b exp %b", $time, got_a, exp_a);
        end
        checks++;
        assert (got_b === exp_b) else begin
            errors++; $error("FAIL line_b t=%0t tx/busy/rdy/done got %b exp %b", $time, got_b, exp_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] x,
                           input logic [7:0] y, input logic [3:0] f, input logic pe, input logic pt);
        cmd_type = t; cmd_addr = a; cmd_d0 = x; cmd_d1 = y; cmd_fun = f; par_en = pe; par_typ = pt;
    endtask

    // One-cycle valid pulse; returns at the negedge of the first busy cycle.
    task automatic send(input logic [1:0] t, input logic [3:0] a, input logic [7:0] x,
                        input logic [7:0] y, input logic [3:0] f, input logic pe, input logic pt);
        set_cmd(t, a, x, y, f, pe, pt);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Cycles from now until CMD_DONE is seen on the chosen instance.
    task automatic wait_done(input bit on_b, output int n);
        n = 0;
        while (((on_b ? done_b : done_a) !== 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || dna || dnb) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 5000) else begin
            errors++; $error("FAIL idle_wait got %0d cycles exp <5000", n);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ndone;
        bit gapless;

        rst = 1'b1; cmd_valid = 1'b0;
        set_cmd(2'd0, 4'h0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ready", 32'(rdy_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write 5 <- 3C: first busy cycle is the start bit; done 256 cycles later.
        send(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0);
        chk("wr_first_tx", 32'(tx_a), 32'd0);
        chk("wr_first_busy", 32'(busy_a), 32'd1);
        chk("wr_first_ready", 32'(rdy_a), 32'd0);
        wait_done(1'b0, n);
        chk("wr_done_cycles", 32'(n), 32'd256);
        chk("wr_done_busy", 32'(busy_a), 32'd0);
        wait_idle();

        // Read 0xA with even then odd parity: check both parity bits and 88-cycle frames.
        for (int pt = 0; pt < 2; pt++) begin
            send(2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 1'b1, 1'(pt));
            repeat (75) @(negedge clk);
            chk("par_bit_bb", 32'(tx_a), 32'(pt));
            repeat (96) @(negedge clk);
            chk("par_bit_0a", 32'(tx_a), 32'(pt));
            wait_done(1'b0, n);
            chk("par_done_cycles", 32'(n), 32'd13);
            wait_idle();
        end

        // ALU with operands on the gapless instance: four contiguous frames.
        send(2'd2, 4'h0, 8'h12, 8'h34, 4'h3, 1'b0, 1'b0);
        gapless = 1'b0;
        n = 0;
        while (done_b !== 1'b1 && n < 3000) begin
            if (busy_b !== 1'b1) gapless = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("alu_b_done_cycles", 32'(n), 32'd160);
        chk("alu_b_busy_dropout", 32'(gapless), 32'd0);
        wait_idle();

        // Back-to-back: valid held, second command taken on the done cycle.
        set_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h1, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        @(negedge clk);
        set_cmd(2'd1, 4'h6, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
        wait_done(1'b0, n);
        chk("b2b_done_cycles", 32'(n), 32'd168);
        chk("b2b_done_ready", 32'(rdy_a), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_start_tx", 32'(tx_a), 32'd0);
        chk("b2b_start_busy", 32'(busy_a), 32'd1);
        wait_idle();

        // Valid pulse while busy is ignored; data changes after accept have no effect.
        send(2'd0, 4'h3, 8'h55, 8'h00, 4'h0, 1'b0, 1'b0);
        ndone = 0;
        repeat (20) @(negedge clk);
        set_cmd(2'd1, 4'hF, 8'hFF, 8'hFF, 4'hF, 1'b1, 1'b1);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || dna || dnb) && n < 3000) begin
            cmd_d0 = 8'($urandom);
            if (done_a === 1'b1) ndone++;
            @(negedge clk);
            n++;
        end
        chk("busy_pulse_done_count", 32'(ndone), 32'd1);
        wait_idle();

        // Reset during a zero data bit of byte 2 (0x09, bit 1).
        send(2'd0, 4'h9, 8'hC3, 8'h00, 4'h0, 1'b0, 1'b0);
        repeat (106) @(negedge clk);
        chk("pre_rst_tx", 32'(tx_a), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx_a), 32'd1);
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        chk("async_rst_ready", 32'(rdy_a), 32'd1);
        chk("async_rst_done", 32'(done_a), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a === 1'b1 || done_b === 1'b1) ndone++;
        end
        chk("post_rst_no_done", 32'(ndone), 32'd0);
        send(2'd0, 4'h7, 8'hE1, 8'h00, 4'h0, 1'b0, 1'b0);
        wait_done(1'b0, n);
        chk("post_rst_wr_cycles", 32'(n), 32'd256);
        wait_idle();

        // Randomized commands with occasional ignored pulses; the model checks every cycle.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(5, 60)) @(negedge clk);
                set_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                        4'($urandom), 1'($urandom), 1'($urandom));
                cmd_valid = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
            end
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
